// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared 8-bit combinational ALU.
// Registers operands for the ALU and holds each requester's result until it is consumed.
module alu_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req0_bp,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_op,
    input  logic       req1_bp,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_y,
    output logic [2:0] rsp0_flags,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_y,
    output logic [2:0] rsp1_flags,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic       alu_bp,
    input  logic [7:0] alu_y,
    input  logic       alu_carry,
    input  logic       alu_negative,
    input  logic       alu_zero
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t     state;
    logic [7:0] opa_q, opb_q;
    logic [2:0] op_q;
    logic       bp_q;
    logic       owner_q;
    logic       last_grant_q;

    logic       elig0, elig1;
    logic       grant;
    logic       accept0, accept1;

    // A requester whose response slot is still full is never eligible.
    assign elig0 = req0_valid && !rsp0_valid;
    assign elig1 = req1_valid && !rsp1_valid;

    // NOTE: assign a default first so every path drives grant and no latch is inferred.
    always_comb begin
        grant = 1'b0;
        if (elig0 && elig1)
            grant = ~last_grant_q;
        else if (elig1)
            grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && !grant && elig0;
    assign req1_ready = (state == IDLE) &&  grant && elig1;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    assign alu_a  = opa_q;
    assign alu_b  = opb_q;
    assign alu_op = op_q;
    assign alu_bp = bp_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            bp_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= ~PRIO_INIT;
            rsp0_valid   <= 1'b0;
            rsp0_y       <= '0;
            rsp0_flags   <= '0;
            rsp1_valid   <= 1'b0;
            rsp1_y       <= '0;
            rsp1_flags   <= '0;
        end else begin
            if (rsp0_valid && rsp0_ready)
                rsp0_valid <= 1'b0;
            if (rsp1_valid && rsp1_ready)
                rsp1_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept0) begin
                        opa_q        <= req0_a;
                        opb_q        <= req0_b;
                        op_q         <= req0_op;
                        bp_q         <= req0_bp;
                        owner_q      <= 1'b0;
                        last_grant_q <= 1'b0;
                        state        <= EXEC;
                    end else if (accept1) begin
                        opa_q        <= req1_a;
                        opb_q        <= req1_b;
                        op_q         <= req1_op;
                        bp_q         <= req1_bp;
                        owner_q      <= 1'b1;
                        last_grant_q <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    // The owner's slot was empty at accept, so this never races its own consume.
                    if (!owner_q) begin
                        rsp0_valid <= 1'b1;
                        rsp0_y     <= alu_y;
                        rsp0_flags <= {alu_carry, alu_negative, alu_zero};
                    end else begin
                        rsp1_valid <= 1'b1;
                        rsp1_y     <= alu_y;
                        rsp1_flags <= {alu_carry, alu_negative, alu_zero};
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table through a small ALU model plus
// contention, backpressure, hold and mid-operation reset sequences.
module tb_alu_arbiter;

    typedef struct {
        int         r;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       bp;
        logic [7:0] exp_y;
        logic [2:0] exp_f;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]      req_valid, req_ready, req_bp, rsp_valid, rsp_ready;
    logic [1:0][7:0] req_a, req_b, rsp_y;
    logic [1:0][2:0] req_op, rsp_flags;
    logic [7:0]      alu_a, alu_b, alu_y;
    logic [2:0]      alu_op;
    logic            alu_bp, alu_carry, alu_negative, alu_zero;

    logic [1:0]      p1_req_ready, p1_rsp_valid;
    logic [1:0][7:0] p1_rsp_y;
    logic [1:0][2:0] p1_rsp_flags;
    logic [7:0]      p1_alu_a, p1_alu_b, p1_alu_y;
    logic [2:0]      p1_alu_op;
    logic            p1_alu_bp, p1_alu_carry, p1_alu_negative, p1_alu_zero;

    int tests  = 0;
    int failed = 0;

    // Reference ALU: returns {carry, negative, zero, y}; negative is carry when bp=1.
    function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op, input logic bp);
        logic [8:0] w;
        case (op)
            3'b000:  w = {1'b0, a & b};
            3'b001:  w = {1'b0, ~a};
            3'b010:  w = {1'b0, a} + {1'b0, b};
            3'b011:  w = {1'b0, a} - {1'b0, b};
            3'b100:  w = {1'b0, a | b};
            3'b101:  w = {1'b0, a ^ b};
            3'b110:  w = {a[7], a[6:0], 1'b0};
            default: w = {a[0], 1'b0, a[7:1]};
        endcase
        return {w[8], bp ? w[8] : w[7], w[7:0] == 8'h00, w[7:0]};
    endfunction

    assign {alu_carry, alu_negative, alu_zero, alu_y} = alu_model(alu_a, alu_b, alu_op, alu_bp);
    assign {p1_alu_carry, p1_alu_negative, p1_alu_zero, p1_alu_y} =
        alu_model(p1_alu_a, p1_alu_b, p1_alu_op, p1_alu_bp);

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_a(req_a[0]),
        .req0_b(req_b[0]), .req0_op(req_op[0]), .req0_bp(req_bp[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_a(req_a[1]),
        .req1_b(req_b[1]), .req1_op(req_op[1]), .req1_bp(req_bp[1]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_y(rsp_y[0]),
        .rsp0_flags(rsp_flags[0]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_y(rsp_y[1]),
        .rsp1_flags(rsp_flags[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_bp(alu_bp),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_negative(alu_negative), .alu_zero(alu_zero)
    );

    alu_arbiter #(.PRIO_INIT(1'b1)) dut_p1 (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(p1_req_ready[0]), .req0_a(req_a[0]),
        .req0_b(req_b[0]), .req0_op(req_op[0]), .req0_bp(req_bp[0]),
        .req1_valid(req_valid[1]), .req1_ready(p1_req_ready[1]), .req1_a(req_a[1]),
        .req1_b(req_b[1]), .req1_op(req_op[1]), .req1_bp(req_bp[1]),
        .rsp0_valid(p1_rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_y(p1_rsp_y[0]),
        .rsp0_flags(p1_rsp_flags[0]),
        .rsp1_valid(p1_rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_y(p1_rsp_y[1]),
        .rsp1_flags(p1_rsp_flags[1]),
        .alu_a(p1_alu_a), .alu_b(p1_alu_b), .alu_op(p1_alu_op), .alu_bp(p1_alu_bp),
        .alu_y(p1_alu_y), .alu_carry(p1_alu_carry), .alu_negative(p1_alu_negative),
        .alu_zero(p1_alu_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on requester r, check EXEC-cycle ALU drive and the captured response.
    task automatic run_op(input vec_t v, input bit consume);
        int k;
        req_a[v.r]     = v.a;
        req_b[v.r]     = v.b;
        req_op[v.r]    = v.op;
        req_bp[v.r]    = v.bp;
        req_valid[v.r] = 1'b1;
        #1;
        k = 0;
        while (!req_ready[v.r] && k < 8) begin
            tick();
            k++;
        end
        check($sformatf("req%0d_ready", v.r), req_ready[v.r], 1);
        tick();
        req_valid[v.r] = 1'b0;
        check("exec alu_a", alu_a, v.a);
        check("exec alu_b", alu_b, v.b);
        check("exec alu_op", alu_op, v.op);
        check("exec alu_bp", alu_bp, v.bp);
        check($sformatf("rsp%0d_valid early", v.r), rsp_valid[v.r], 0);
        tick();
        check($sformatf("rsp%0d_valid", v.r), rsp_valid[v.r], 1);
        check($sformatf("rsp%0d_y", v.r), rsp_y[v.r], v.exp_y);
        check($sformatf("rsp%0d_flags", v.r), rsp_flags[v.r], v.exp_f);
        if (consume) begin
            rsp_ready[v.r] = 1'b1;
            tick();
            rsp_ready[v.r] = 1'b0;
            check($sformatf("rsp%0d_valid consumed", v.r), rsp_valid[v.r], 0);
        end
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        vecs[0] = '{0, 8'h05, 8'h03, 3'b010, 1'b0, 8'h08, 3'b000};
        vecs[1] = '{1, 8'hFF, 8'h01, 3'b010, 1'b1, 8'h00, 3'b111};
        vecs[2] = '{0, 8'h10, 8'h01, 3'b011, 1'b0, 8'h0F, 3'b000};
        vecs[3] = '{1, 8'h01, 8'h02, 3'b011, 1'b0, 8'hFF, 3'b110};
        vecs[4] = '{0, 8'hAA, 8'h00, 3'b001, 1'b0, 8'h55, 3'b000};
        vecs[5] = '{1, 8'h80, 8'h80, 3'b010, 1'b0, 8'h00, 3'b101};
        vecs[6] = '{0, 8'hF0, 8'h0F, 3'b000, 1'b0, 8'h00, 3'b001};
        vecs[7] = '{1, 8'hC3, 8'h00, 3'b110, 1'b0, 8'h86, 3'b110};

        reset     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_a     = {8'h02, 8'h01};
        req_b     = {8'h02, 8'h01};
        req_op    = {3'b010, 3'b010};
        req_bp    = 2'b00;
        #12;
        check("reset alu_a", alu_a, 0);
        check("reset alu_b", alu_b, 0);
        check("reset alu_op", alu_op, 0);
        check("reset alu_bp", alu_bp, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp0_y", rsp_y[0], 0);
        check("reset rsp1_flags", rsp_flags[1], 0);

        // Contention from reset: PRIO_INIT=0 grants 0,1,0,1; PRIO_INIT=1 grants 1 first.
        tick();
        reset = 1'b1;
        check("p1 first grant req1", p1_req_ready[1], 1);
        check("p1 first grant req0", p1_req_ready[0], 0);
        for (int i = 0; i < 4; i++) begin
            int k = 0;
            while (req_ready == 2'b00 && k < 8) begin
                tick();
                k++;
            end
            check($sformatf("contention one grant %0d", i), req_ready == 2'b01 || req_ready == 2'b10, 1);
            check($sformatf("contention grant %0d", i), req_ready[1], i % 2);
            tick();
        end
        req_valid = 2'b00;
        repeat (3) tick();
        rsp_ready = 2'b00;
        check("contention drained", rsp_valid, 0);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i], 1'b1);

        // Backpressure and hold: rsp0 stays full while req1 runs and req0 keeps asking.
        run_op('{0, 8'h05, 8'h03, 3'b010, 1'b0, 8'h08, 3'b000}, 1'b0);
        req_a[0]     = 8'h11;
        req_b[0]     = 8'h22;
        req_op[0]    = 3'b010;
        req_bp[0]    = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        check("bp req0_ready blocked", req_ready[0], 0);
        run_op('{1, 8'hAA, 8'h00, 3'b001, 1'b0, 8'h55, 3'b000}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("hold rsp0_valid", rsp_valid[0], 1);
            check("hold rsp0_y", rsp_y[0], 8'h08);
            check("hold rsp0_flags", rsp_flags[0], 3'b000);
            check("hold req0_ready", req_ready[0], 0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        check("bp rsp0 cleared", rsp_valid[0], 0);
        check("bp req0_ready after consume", req_ready[0], 1);
        tick();
        req_valid[0] = 1'b0;
        check("bp exec alu_a", alu_a, 8'h11);
        tick();
        check("bp rsp0_valid", rsp_valid[0], 1);
        check("bp rsp0_y", rsp_y[0], 8'h33);
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;

        // Reset during EXEC discards the operation.
        req_a[0]     = 8'h10;
        req_b[0]     = 8'h01;
        req_op[0]    = 3'b011;
        req_valid[0] = 1'b1;
        #1;
        check("rst req0_ready", req_ready[0], 1);
        tick();
        req_valid[0] = 1'b0;
        check("rst exec alu_a", alu_a, 8'h10);
        reset = 1'b0;
        #1;
        check("rst alu_a", alu_a, 0);
        check("rst alu_op", alu_op, 0);
        check("rst rsp0_valid", rsp_valid[0], 0);
        check("rst rsp0_y", rsp_y[0], 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("post-rst rsp0_valid", rsp_valid[0], 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
